// File: rtl/eth_tx_pkt_ingress_fifo.sv
// Ingress buffer for the 10G MAC transmit packet interface: framing check,
// first-word-fall-through FIFO with a reserved termination slot, and counters.
module eth_tx_pkt_ingress_fifo #(
    parameter int DEPTH       = 16,
    parameter int FULL_MARGIN = 4,
    parameter int DATA_W      = 64
) (
    input  logic              clk156m25,
    input  logic              reset_156m25_n,
    input  logic [DATA_W-1:0] pkt_tx_data,
    input  logic              pkt_tx_sop,
    input  logic              pkt_tx_eop,
    input  logic [2:0]        pkt_tx_mod,
    input  logic              pkt_tx_val,
    output logic              pkt_tx_full,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [2:0]        out_mod,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              framing_err,
    output logic              overflow,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = DATA_W + 6;
    localparam logic [CW-1:0] SPACE_LIM = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_LIM  = CW'(DEPTH - 1 - FULL_MARGIN);

    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

    state_t              state, state_next;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count, count_next;
    logic                space, push, push_term, push_any, pop;
    logic                fe_next, ov_next;
    logic [ENTRY_W-1:0]  wr_entry, head;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign space    = (count < SPACE_LIM);
    assign push_any = push | push_term;
    assign pop      = out_valid & out_ready;
    assign wr_entry = push_term ? {{DATA_W{1'b0}}, 1'b0, 1'b1, 3'd0, 1'b1}
                                : {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, 1'b0};

    // Framing decision for the word presented this cycle
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_term  = 1'b0;
        fe_next    = 1'b0;
        ov_next    = 1'b0;
        if (pkt_tx_val) begin
            case (state)
                IDLE: begin
                    if (!pkt_tx_sop) begin
                        fe_next = 1'b1;
                        if (!pkt_tx_eop) state_next = DROP;
                    end else if (space) begin
                        push = 1'b1;
                        if (!pkt_tx_eop) state_next = IN_PKT;
                    end else begin
                        ov_next = 1'b1;
                        if (!pkt_tx_eop) state_next = DROP;
                    end
                end
                IN_PKT: begin
                    if (pkt_tx_sop) begin
                        push_term  = 1'b1;
                        fe_next    = 1'b1;
                        state_next = pkt_tx_eop ? IDLE : DROP;
                    end else if (space) begin
                        push = 1'b1;
                        if (pkt_tx_eop) state_next = IDLE;
                    end else begin
                        // The reserved last slot is always free while in a packet
                        push_term  = 1'b1;
                        ov_next    = 1'b1;
                        state_next = pkt_tx_eop ? IDLE : DROP;
                    end
                end
                DROP: begin
                    if (pkt_tx_eop) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        count_next = count;
        case ({push_any, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pkt_tx_full <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
            pkt_count   <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            pkt_tx_full <= (count_next >= FULL_LIM);
            framing_err <= fe_next;
            overflow    <= ov_next;
            if (push_any) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            if (push && pkt_tx_eop)  pkt_count <= sat_inc(pkt_count);
            if (fe_next || ov_next)  err_count <= sat_inc(err_count);
        end
    end

    // Storage carries data only; emptiness is tracked by count
    always_ff @(posedge clk156m25) begin
        if (push_any) mem[wr_ptr] <= wr_entry;
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head[ENTRY_W-1:6] : '0;
    assign out_sop   = out_valid & head[5];
    assign out_eop   = out_valid & head[4];
    assign out_mod   = out_valid ? head[3:1] : 3'd0;
    assign out_err   = out_valid & head[0];

endmodule

// File: tb/tb_eth_tx_pkt_ingress_fifo.sv
// Scoreboard bench for eth_tx_pkt_ingress_fifo: directed packets, expected
// FIFO entries queued at stimulus time, popped by an output monitor.
module tb_eth_tx_pkt_ingress_fifo;

    logic        clk156m25 = 1'b0;
    logic        reset_156m25_n;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_sop, pkt_tx_eop, pkt_tx_val;
    logic [2:0]  pkt_tx_mod;
    logic        pkt_tx_full;
    logic [63:0] out_data;
    logic        out_sop, out_eop, out_err, out_valid, out_ready;
    logic [2:0]  out_mod;
    logic        framing_err, overflow;
    logic [15:0] pkt_count, err_count;

    int checks   = 0;
    int failures = 0;
    int fe_seen  = 0;
    int ov_seen  = 0;
    logic [69:0] exp_q [$];

    eth_tx_pkt_ingress_fifo dut (
        .clk156m25      (clk156m25),
        .reset_156m25_n (reset_156m25_n),
        .pkt_tx_data    (pkt_tx_data),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_full    (pkt_tx_full),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_mod        (out_mod),
        .out_err        (out_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .framing_err    (framing_err),
        .overflow       (overflow),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    always #5 clk156m25 = ~clk156m25;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every accepted head word is compared with the scoreboard
    always @(negedge clk156m25) begin
        if (reset_156m25_n) begin
            if (framing_err) fe_seen++;
            if (overflow)    ov_seen++;
            if (framing_err && overflow) begin
                checks++;
                failures++;
                $display("FAIL pulse_overlap: framing_err and overflow both high");
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got data=%0h sop=%0b eop=%0b mod=%0d err=%0b with empty scoreboard",
                             out_data, out_sop, out_eop, out_mod, out_err);
                end else begin
                    logic [69:0] e;
                    e = exp_q.pop_front();
                    if ({out_data, out_sop, out_eop, out_mod, out_err} !== e) begin
                        failures++;
                        $display("FAIL head_word: got data=%0h sop=%0b eop=%0b mod=%0d err=%0b expected data=%0h sop=%0b eop=%0b mod=%0d err=%0b",
                                 out_data, out_sop, out_eop, out_mod, out_err,
                                 e[69:6], e[5], e[4], e[3:1], e[0]);
                    end
                end
            end
        end
    end

    task automatic idle();
        pkt_tx_val  = 1'b0;
        pkt_tx_sop  = 1'b0;
        pkt_tx_eop  = 1'b0;
        pkt_tx_mod  = 3'd0;
        pkt_tx_data = '0;
    endtask

    // Present one word for one clock; returns 1 time unit after the edge
    task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
        pkt_tx_data = d;
        pkt_tx_sop  = s;
        pkt_tx_eop  = e;
        pkt_tx_mod  = m;
        pkt_tx_val  = 1'b1;
        @(posedge clk156m25);
        #1;
        idle();
    endtask

    task automatic expect_word(input logic [63:0] d, input logic s, input logic e,
                               input logic [2:0] m, input logic err);
        exp_q.push_back({d, s, e, m, err});
    endtask

    task automatic expect_term();
        exp_q.push_back({64'h0, 1'b0, 1'b1, 3'd0, 1'b1});
    endtask

    task automatic drain(input string name);
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk156m25);
            #1;
            n++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset_156m25_n = 1'b0;
        out_ready      = 1'b0;
        idle();
        repeat (3) @(posedge clk156m25);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_full", 64'(pkt_tx_full), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_pulses", 64'({framing_err, overflow}), 64'd0);
        reset_156m25_n = 1'b1;
        @(posedge clk156m25);
        #1;

        // 3-word packet with consumer always ready
        out_ready = 1'b1;
        expect_word(64'h1111, 1'b1, 1'b0, 3'd0, 1'b0);
        send(64'h1111, 1'b1, 1'b0, 3'd0);
        chk("t1_valid_after_d0", 64'(out_valid), 64'd1);
        expect_word(64'h2222, 1'b0, 1'b0, 3'd0, 1'b0);
        send(64'h2222, 1'b0, 1'b0, 3'd0);
        expect_word(64'h3333, 1'b0, 1'b1, 3'd5, 1'b0);
        send(64'h3333, 1'b0, 1'b1, 3'd5);
        drain("t1");
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);
        chk("t1_err_count", 64'(err_count), 64'd0);

        // 14-word packet into a stalled FIFO, full asserts at count 11
        out_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            expect_word(64'h200 + 64'(i), i == 1, i == 14, 3'(i), 1'b0);
            send(64'h200 + 64'(i), i == 1, i == 14, 3'(i));
            chk($sformatf("t2_full_w%0d", i), 64'(pkt_tx_full), 64'(i >= 11));
        end
        chk("t2_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk156m25);
            #1;
            chk($sformatf("t2_drain_full_%0d", k), 64'(pkt_tx_full), 64'((14 - k) >= 11));
        end
        drain("t2");
        chk("t2_pkt_count", 64'(pkt_count), 64'd2);

        // 20-word packet ignoring full: 15 stored, then termination, rest dropped
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i <= 15) expect_word(64'h300 + 64'(i), i == 1, 1'b0, 3'd1, 1'b0);
            else if (i == 16) expect_term();
            send(64'h300 + 64'(i), i == 1, i == 20, 3'd1);
            if (i == 16) chk("t3_overflow_pulse", 64'(overflow), 64'd1);
            if (i == 17) chk("t3_overflow_once", 64'(overflow), 64'd0);
        end
        chk("t3_err_count", 64'(err_count), 64'd1);
        chk("t3_pkt_count", 64'(pkt_count), 64'd2);
        chk("t3_full", 64'(pkt_tx_full), 64'd1);
        drain("t3");

        // sop inside a packet terminates it; following packet is clean
        out_ready = 1'b1;
        expect_word(64'h401, 1'b1, 1'b0, 3'd0, 1'b0);
        send(64'h401, 1'b1, 1'b0, 3'd0);
        expect_word(64'h402, 1'b0, 1'b0, 3'd0, 1'b0);
        send(64'h402, 1'b0, 1'b0, 3'd0);
        expect_term();
        send(64'h403, 1'b1, 1'b0, 3'd0);
        chk("t4_framing_pulse", 64'(framing_err), 64'd1);
        send(64'h404, 1'b0, 1'b0, 3'd0);
        chk("t4_no_second_pulse", 64'(framing_err), 64'd0);
        send(64'h405, 1'b0, 1'b1, 3'd2);
        expect_word(64'h4AA, 1'b1, 1'b1, 3'd7, 1'b0);
        send(64'h4AA, 1'b1, 1'b1, 3'd7);
        drain("t4");
        chk("t4_pkt_count", 64'(pkt_count), 64'd3);
        chk("t4_err_count", 64'(err_count), 64'd2);

        // Stray mid-packet word while idle, then its eop
        send(64'h5, 1'b0, 1'b0, 3'd0);
        chk("t5_framing_pulse", 64'(framing_err), 64'd1);
        chk("t5_fifo_unchanged", 64'(out_valid), 64'd0);
        send(64'h6, 1'b0, 1'b1, 3'd0);
        chk("t5_eop_no_pulse", 64'({framing_err, overflow}), 64'd0);
        chk("t5_fifo_still_empty", 64'(out_valid), 64'd0);
        chk("t5_err_count", 64'(err_count), 64'd3);

        // Reset mid-packet with 6 words buffered
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(64'h600 + 64'(i), i == 1, 1'b0, 3'd0);
        chk("t6_valid_before_rst", 64'(out_valid), 64'd1);
        reset_156m25_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_full", 64'(pkt_tx_full), 64'd0);
        chk("t6_rst_counters", {32'd0, pkt_count, err_count}, 64'd0);
        @(posedge clk156m25);
        #1;
        reset_156m25_n = 1'b1;
        @(posedge clk156m25);
        #1;
        out_ready = 1'b1;
        expect_word(64'h6AB, 1'b1, 1'b1, 3'd3, 1'b0);
        send(64'h6AB, 1'b1, 1'b1, 3'd3);
        drain("t6");
        chk("t6_pkt_count", 64'(pkt_count), 64'd1);

        chk("total_framing_pulses", 64'(fe_seen), 64'd2);
        chk("total_overflow_pulses", 64'(ov_seen), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_tx_pkt_ingress_fifo.md
Name: eth_tx_pkt_ingress_fifo

Overview:
- Receiving end of the 10G MAC transmit packet interface: sinks pkt_tx_data/sop/eop/mod/val and generates pkt_tx_full.
- Checks packet framing, buffers words in a DEPTH-entry FIFO and presents them to the MAC transmit engine through a valid/ready stream.
- Keeps packet and error counters.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >= 8); the last entry is reserved for termination words.
FULL_MARGIN, 4, headroom entries covering sender reaction latency to pkt_tx_full.

Ports:
clk156m25  input  1  156.25 MHz clock
reset_156m25_n  input  1  asynchronous active-low reset
pkt_tx_data  input  64  packet data word
pkt_tx_sop  input  1  first word of packet
pkt_tx_eop  input  1  last word of packet
pkt_tx_mod  input  3  valid bytes on eop word (0 = all 8)
pkt_tx_val  input  1  word valid this cycle
pkt_tx_full  output  1  stop-sending indication to packet source
out_data  output  64  head word data
out_sop  output  1  head word sop
out_eop  output  1  head word eop
out_mod  output  3  head word mod
out_err  output  1  head word is an error-termination word
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts head word
framing_err  output  1  one-cycle pulse on framing violation
overflow  output  1  one-cycle pulse on word lost to full FIFO
pkt_count  output  16  good packets written (eop, err=0), saturating
err_count  output  16  framing_err + overflow events, saturating

Behaviour:
- Reset (async assert, sync release) clears everything: FIFO empty, FSM IDLE, count=0.
- Reset values of outputs: pkt_tx_full=0, out_valid=0, out_* = 0, framing_err=0, overflow=0, both counters=0.
- Reset mid-packet discards all buffered words.
- One clock domain, fully synchronous apart from reset.
- FIFO entry = {data, sop, eop, mod, err}. First-word-fall-through: out_* reflect the head entry; out_valid = (count != 0).
- Pop occurs when out_valid & out_ready.
- A word accepted at edge N is visible on out_* after edge N; minimum 1-cycle latency.
- Push and pop in the same cycle leave count unchanged.
- Accept decisions use count from before the edge; no pop-through.
- "space" = count < DEPTH-1, i.e. a normal slot is free.
- Termination word: data=0, sop=0, eop=1, mod=0, err=1. It may use the reserved last slot.
- pkt_tx_full is registered, = (count >= DEPTH-1-FULL_MARGIN). Defaults: full when count >= 11.
- mod is stored unmodified on every word and is meaningful only on eop words.
- Framing FSM, states IDLE, IN_PKT, DROP. Evaluated only when pkt_tx_val=1; val=0 means no state change.
- IDLE:
  - sop & space: write word. Go IN_PKT if !eop, stay IDLE if eop.
  - sop & !space: discard word, overflow pulse. Go DROP if !eop.
  - !sop: discard word, framing_err pulse. Go DROP if !eop, else stay IDLE.
- IN_PKT:
  - !sop & space: write word. eop returns to IDLE.
  - !sop & !space: write termination word into the reserved slot, overflow pulse. Go DROP if !eop, else IDLE.
  - sop (any space): write termination word, framing_err pulse, drop the offending word. Go DROP if !eop, else IDLE.
- DROP: discard words silently (no pulse, no count). A word with eop returns to IDLE.
- Guarantee: the reserved slot is free whenever the FSM is in IN_PKT, so a termination word never overflows.
- pkt_count: +1 per written word with eop=1, err=0.
- err_count: +1 per framing_err or overflow pulse. Both saturate at 16'hFFFF.
- framing_err and overflow are registered pulses, asserted the cycle after the offending word; never both in one cycle.

Test Plan:
- 3-word packet (sop D0=64'h1111, D1, eop D2 mod=5), out_ready=1 -> out_valid from cycle after D0; words emerge in order, out_eop=1 with out_mod=5 on D2, pkt_count=1, no pulses.
- out_ready=0, 14-word packet streamed -> pkt_tx_full rises the cycle after the 11th accept; all 14 words stored; overflow=0. Then out_ready=1 drains all 14 words; pkt_tx_full falls once count < 11.
- out_ready=0, 20-word packet ignoring full -> words 1-15 stored; word 16 yields a termination word (eop=1, err=1) and one overflow pulse; words 17-20 dropped; count=16, err_count=1, pkt_count=0.
- sop at word 3 of a packet, no eop until word 5 -> entry 3 is a termination word, one framing_err pulse, words 3-5 dropped; the next sop packet is accepted normally.
- val=1, sop=0, eop=0 while IDLE -> framing_err pulse, FIFO unchanged, FSM DROP; the following eop word returns the FSM to IDLE with no further pulse.
- reset_156m25_n low for one cycle mid-packet with count=6 -> immediately out_valid=0, pkt_tx_full=0, counters=0; a following clean 1-word packet (sop=eop=1) is accepted.
